// File: rtl/imem_loader.sv
// Instruction memory with a valid/ready program loader that holds the core in reset until loaded.
// Define IMEM_CHECKSUM_EN to build the running load checksum on csum_o.
module imem_loader #(
    parameter int                ADDR_W    = 8,
    parameter int                INST_W    = 16,
    parameter logic [INST_W-1:0] FILL_WORD = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid_i,
    output logic              ld_ready_o,
    input  logic [INST_W-1:0] ld_data_i,
    input  logic              ld_last_i,
    input  logic              reload_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [INST_W-1:0] inst_o,
    output logic              core_run_o,
    output logic [ADDR_W:0]   count_o,
    output logic              trunc_o,
    output logic [INST_W-1:0] csum_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] TOP = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state, state_nxt;
    logic [ADDR_W:0] count, count_nxt;
    logic trunc, trunc_nxt;
    logic run, run_nxt;
    logic accept;
    logic [INST_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= LOAD;
            count <= '0;
            trunc <= 1'b0;
            run   <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            trunc <= trunc_nxt;
            run   <= run_nxt;
        end
    end

    // Reload always wins over a same-cycle handshake.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        trunc_nxt = trunc;
        accept    = 1'b0;
        unique case (state)
            LOAD: begin
                if (reload_i) begin
                    count_nxt = '0;
                    trunc_nxt = 1'b0;
                end else if (ld_valid_i) begin
                    accept    = 1'b1;
                    count_nxt = count + 1'b1;
                    if (ld_last_i) begin
                        state_nxt = RUN;
                    end else if (count == TOP) begin
                        state_nxt = RUN;
                        trunc_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                if (reload_i) begin
                    state_nxt = LOAD;
                    count_nxt = '0;
                    trunc_nxt = 1'b0;
                end
            end
        endcase
        run_nxt = (state_nxt == RUN);
    end

    // Storage has no reset; stale words are hidden by the count mask.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[count[ADDR_W-1:0]] <= ld_data_i;
        end
    end

    assign inst_o = ({1'b0, addr_i} < count) ? mem[addr_i] : FILL_WORD;

    assign ld_ready_o = (state == LOAD);
    assign core_run_o = run;
    assign count_o    = count;
    assign trunc_o    = trunc;

`ifdef IMEM_CHECKSUM_EN
    logic [INST_W-1:0] csum, csum_nxt;

    always_comb begin
        csum_nxt = csum;
        if (reload_i) begin
            csum_nxt = '0;
        end else if (accept) begin
            csum_nxt = csum + ld_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum <= '0;
        end else begin
            csum <= csum_nxt;
        end
    end

    assign csum_o = csum;
`else
    assign csum_o = '0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (ADDR_W=8 main instance, ADDR_W=2 capacity instance).
module tb_imem_loader;

`ifdef IMEM_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    logic        v, l, r;
    logic [15:0] d;
    logic [7:0]  a;
    logic        rdy, run, tr;
    logic [15:0] inst, cs;
    logic [8:0]  cnt;

    logic        v2, l2, r2;
    logic [15:0] d2;
    logic [1:0]  a2;
    logic        rdy2, run2, tr2;
    logic [15:0] inst2, cs2;
    logic [2:0]  cnt2;

    int passes = 0;
    int total  = 0;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(8), .INST_W(16), .FILL_WORD(16'h0000)) dut (
        .clk(clk), .rst(rst),
        .ld_valid_i(v), .ld_ready_o(rdy), .ld_data_i(d), .ld_last_i(l),
        .reload_i(r), .addr_i(a), .inst_o(inst), .core_run_o(run),
        .count_o(cnt), .trunc_o(tr), .csum_o(cs)
    );

    imem_loader #(.ADDR_W(2), .INST_W(16), .FILL_WORD(16'h0000)) dut2 (
        .clk(clk), .rst(rst),
        .ld_valid_i(v2), .ld_ready_o(rdy2), .ld_data_i(d2), .ld_last_i(l2),
        .reload_i(r2), .addr_i(a2), .inst_o(inst2), .core_run_o(run2),
        .count_o(cnt2), .trunc_o(tr2), .csum_o(cs2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [7:0] ad,
                      input logic [15:0] exp);
        a = ad;
        #1;
        chk(tag, 32'(inst), 32'(exp));
    endtask

    initial begin
        rst = 1'b0;
        v = 0; l = 0; r = 0; d = '0; a = '0;
        v2 = 0; l2 = 0; r2 = 0; d2 = '0; a2 = '0;
        #12;
        rst = 1'b1;
        #1;
        chk("rst_ready", 32'(rdy), 1);
        chk("rst_run", 32'(run), 0);
        chk("rst_count", 32'(cnt), 0);
        chk("rst_trunc", 32'(tr), 0);
        chk("rst_csum", 32'(cs), 0);
        rd("rst_inst0", 8'd0, 16'h0000);

        // capacity: ADDR_W=2, five words, no last
        for (int i = 0; i < 5; i++) begin
            v2 = 1'b1;
            d2 = 16'(16'h0A + i);
            if (i == 4) chk("cap_ready5", 32'(rdy2), 0);
            tick();
            chk($sformatf("cap_count%0d", i), 32'(cnt2), (i < 4) ? i + 1 : 4);
            if (i == 2) chk("cap_trunc_pre", 32'(tr2), 0);
            if (i == 2) chk("cap_run_pre", 32'(run2), 0);
        end
        v2 = 1'b0;
        chk("cap_trunc", 32'(tr2), 1);
        chk("cap_run", 32'(run2), 1);
        chk("cap_ready", 32'(rdy2), 0);
        chk("cap_csum", 32'(cs2), CS ? 32'h2E : 0);
        a2 = 2'd3;
        #1;
        chk("cap_inst3", 32'(inst2), 32'h0D);

        // basic 3-word load
        v = 1; d = 16'h1111; l = 0;
        tick();
        chk("ld_cnt1", 32'(cnt), 1);
        rd("ld_early0", 8'd0, 16'h1111);
        d = 16'h2222;
        tick();
        chk("ld_run_pre", 32'(run), 0);
        d = 16'h3333; l = 1;
        tick();
        v = 0; l = 0;
        chk("ld_run", 32'(run), 1);
        chk("ld_ready", 32'(rdy), 0);
        chk("ld_count", 32'(cnt), 3);
        chk("ld_trunc", 32'(tr), 0);
        chk("ld_csum", 32'(cs), CS ? 32'h6666 : 0);
        rd("ld_a0", 8'd0, 16'h1111);
        rd("ld_a1", 8'd1, 16'h2222);
        rd("ld_a2", 8'd2, 16'h3333);
        rd("ld_a3", 8'd3, 16'h0000);

        // valid ignored in RUN
        v = 1; d = 16'hBEEF;
        tick();
        v = 0;
        chk("run_frozen", 32'(cnt), 3);

        // reload then single word
        r = 1;
        tick();
        r = 0;
        chk("rl_run", 32'(run), 0);
        chk("rl_ready", 32'(rdy), 1);
        chk("rl_count", 32'(cnt), 0);
        chk("rl_csum", 32'(cs), 0);
        rd("rl_mask0", 8'd0, 16'h0000);
        v = 1; d = 16'hABCD; l = 1;
        tick();
        v = 0; l = 0;
        chk("rl_run2", 32'(run), 1);
        chk("rl_count1", 32'(cnt), 1);
        rd("rl_a0", 8'd0, 16'hABCD);
        rd("rl_a1", 8'd1, 16'h0000);

        // throttled host, 4 words, decoys with last=1 while invalid
        r = 1;
        tick();
        r = 0;
        for (int i = 0; i < 8; i++) begin
            v = (i % 2 == 0);
            d = v ? 16'(16'h0101 * (i / 2 + 1)) : 16'hDEAD;
            l = (i == 6) || !v;
            tick();
            chk($sformatf("thr_cnt%0d", i), 32'(cnt), i / 2 + 1);
            if (i < 6) chk($sformatf("thr_run%0d", i), 32'(run), 0);
        end
        v = 0; l = 0;
        chk("thr_run", 32'(run), 1);
        chk("thr_csum", 32'(cs), CS ? 32'h0A0A : 0);
        rd("thr_a0", 8'd0, 16'h0101);
        rd("thr_a1", 8'd1, 16'h0202);
        rd("thr_a2", 8'd2, 16'h0303);
        rd("thr_a3", 8'd3, 16'h0404);
        rd("thr_a4", 8'd4, 16'h0000);

        // reload in LOAD with a same-cycle handshake
        r = 1;
        tick();
        r = 0;
        v = 1; d = 16'h1234; l = 0;
        tick();
        chk("rh_cnt1", 32'(cnt), 1);
        chk("rh_cs1", 32'(cs), CS ? 32'h1234 : 0);
        d = 16'h7777; l = 1; r = 1;
        tick();
        v = 0; l = 0; r = 0;
        chk("rh_count", 32'(cnt), 0);
        chk("rh_run", 32'(run), 0);
        chk("rh_ready", 32'(rdy), 1);
        chk("rh_csum", 32'(cs), 0);
        rd("rh_a0", 8'd0, 16'h0000);

        // async reset mid-load
        v = 1; d = 16'h1111;
        tick();
        d = 16'h2222;
        tick();
        v = 0;
        chk("ar_pre", 32'(cnt), 2);
        rst = 1'b0;
        #1;
        chk("ar_count", 32'(cnt), 0);
        chk("ar_ready", 32'(rdy), 1);
        chk("ar_run", 32'(run), 0);
        chk("ar_csum", 32'(cs), 0);
        chk("ar_trunc2", 32'(tr2), 0);
        rd("ar_a0", 8'd0, 16'h0000);
        rst = 1'b1;
        tick();
        chk("ar_hold", 32'(cnt), 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
